// File: rtl/rv64g_l1_line_sequencer_if.sv
// Scalar line-move bus: job request, writeback stream, refill stream and array scalar port.
interface rv64g_l1_line_sequencer_if #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 53
);
  // Job request and status
  logic               start_i;
  logic               start_evict_i;
  logic [INDEX_W-1:0] start_index_i;
  logic [2:0]         start_way_i;
  logic [TAG_W-1:0]   start_tag_i;
  logic [1:0]         start_state_i;
  logic               busy_o;
  logic               done_o;
  // Eviction writeback stream
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [63:0]        wb_data_o;
  logic               wb_last_o;
  // Refill stream
  logic               fill_valid_i;
  logic               fill_ready_o;
  logic [63:0]        fill_data_i;
  // Array scalar port
  logic               arr_req_o;
  logic               arr_we_o;
  logic               arr_tag_we_o;
  logic [INDEX_W-1:0] arr_index_o;
  logic [2:0]         arr_word_o;
  logic [2:0]         arr_way_o;
  logic [7:0]         arr_be_o;
  logic [63:0]        arr_wdata_o;
  logic [TAG_W-1:0]   arr_tag_o;
  logic [1:0]         arr_state_o;
  logic [63:0]        arr_rdata_i;

  // Sequencer side
  modport master (
    input  start_i, start_evict_i, start_index_i, start_way_i, start_tag_i, start_state_i,
    output busy_o, done_o,
    output wb_valid_o, wb_data_o, wb_last_o,
    input  wb_ready_i,
    input  fill_valid_i, fill_data_i,
    output fill_ready_o,
    output arr_req_o, arr_we_o, arr_tag_we_o, arr_index_o, arr_word_o, arr_way_o,
    output arr_be_o, arr_wdata_o, arr_tag_o, arr_state_o,
    input  arr_rdata_i
  );

  // Miss FSM / stream / array side
  modport slave (
    output start_i, start_evict_i, start_index_i, start_way_i, start_tag_i, start_state_i,
    input  busy_o, done_o,
    input  wb_valid_o, wb_data_o, wb_last_o,
    output wb_ready_i,
    output fill_valid_i, fill_data_i,
    input  fill_ready_o,
    input  arr_req_o, arr_we_o, arr_tag_we_o, arr_index_o, arr_word_o, arr_way_o,
    input  arr_be_o, arr_wdata_o, arr_tag_o, arr_state_o,
    output arr_rdata_i
  );
endinterface

// File: rtl/rv64g_l1_line_sequencer.sv
// L1 line-move sequencer: optional dirty eviction readout, 8-beat refill, tag/state write.
module rv64g_l1_line_sequencer #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 53,
  parameter int unsigned WAYS    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  rv64g_l1_line_sequencer_if.master   bus
);

  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EV_RD   = 3'd1,
    S_EV_CAP  = 3'd2,
    S_EV_SEND = 3'd3,
    S_FILL    = 3'd4,
    S_TAG_WR  = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [INDEX_W-1:0] r_index;
  logic [WAY_W-1:0]   r_way;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_line_st;
  logic [63:0]        r_wb_data;
  logic               w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_W'(7));

  // Job latch, word counter, eviction capture and phase sequencing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_index   <= '0;
      r_way     <= '0;
      r_tag     <= '0;
      r_line_st <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_index   <= bus.start_index_i;
            r_way     <= WAY_W'(bus.start_way_i);
            r_tag     <= bus.start_tag_i;
            r_line_st <= bus.start_state_i;
            r_cnt     <= '0;
            r_state   <= bus.start_evict_i ? S_EV_RD : S_FILL;
          end
        end
        S_EV_RD:  r_state <= S_EV_CAP;
        S_EV_CAP: begin
          r_wb_data <= bus.arr_rdata_i;
          r_state   <= S_EV_SEND;
        end
        S_EV_SEND: begin
          if (bus.wb_ready_i) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= S_FILL;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= S_EV_RD;
            end
          end
        end
        S_FILL: begin
          if (bus.fill_valid_i) begin
            if (w_cnt_last) r_state <= S_TAG_WR;
            else            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_TAG_WR: r_state <= S_DONE;
        S_DONE:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; refill writes pass the beat straight through
  always_comb begin
    bus.busy_o       = (r_state != S_IDLE);
    bus.done_o       = 1'b0;
    bus.wb_valid_o   = 1'b0;
    bus.wb_last_o    = 1'b0;
    bus.wb_data_o    = r_wb_data;
    bus.fill_ready_o = 1'b0;
    bus.arr_req_o    = 1'b0;
    bus.arr_we_o     = 1'b0;
    bus.arr_tag_we_o = 1'b0;
    bus.arr_index_o  = r_index;
    bus.arr_way_o    = 3'(r_way);
    bus.arr_word_o   = '0;
    bus.arr_be_o     = '0;
    bus.arr_wdata_o  = '0;
    bus.arr_tag_o    = '0;
    bus.arr_state_o  = '0;
    case (r_state)
      S_EV_RD: begin
        bus.arr_req_o  = 1'b1;
        bus.arr_word_o = r_cnt;
      end
      S_EV_SEND: begin
        bus.wb_valid_o = 1'b1;
        bus.wb_last_o  = w_cnt_last;
      end
      S_FILL: begin
        bus.fill_ready_o = 1'b1;
        if (bus.fill_valid_i) begin
          bus.arr_req_o   = 1'b1;
          bus.arr_we_o    = 1'b1;
          bus.arr_word_o  = r_cnt;
          bus.arr_be_o    = 8'hFF;
          bus.arr_wdata_o = bus.fill_data_i;
        end
      end
      S_TAG_WR: begin
        bus.arr_tag_we_o = 1'b1;
        bus.arr_tag_o    = r_tag;
        bus.arr_state_o  = r_line_st;
      end
      S_DONE:  bus.done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
